seq_multiplier: RTL and testbench
=================================

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-004 SHALL have port start, input, 1, request to begin a multiply; sampled only when busy=0.
REQ-005 SHALL have port signed_mode, input, 1, 1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 SHALL have port a, input, WIDTH, multiplicand; sampled with start.
REQ-007 SHALL have port b, input, WIDTH, multiplier; sampled with start.
REQ-008 SHALL have port busy, output, 1, high while a multiply is in progress.
REQ-009 SHALL have port done, output, 1, single-cycle pulse marking a new result on p.
REQ-010 SHALL have port p, output, 2*WIDTH, registered product.

Function
REQ-011 SHALL be a radix-2 shift-add multiplier with FSM states IDLE, RUN, FIX.
REQ-012 Accept: on a rising edge with start=1 and busy=0, SHALL capture a, b and signed_mode, clear the accumulator, load the iteration counter with WIDTH, and enter RUN.
REQ-013 start while busy=1 SHALL be ignored, and operand inputs SHALL have no effect.
REQ-014 Capture in signed mode: operands SHALL be stored as magnitudes, and result sign = a[WIDTH-1] XOR b[WIDTH-1].
REQ-015 Capture in unsigned mode: operands SHALL be stored as-is, and result sign = 0.
REQ-016 Each RUN edge SHALL add the multiplicand to the upper accumulator half when the current multiplier LSB is 1, then shift right by one bit, including the carry-out, and decrement the counter.
REQ-017 When the counter reaches 0 after the WIDTH-th iteration, SHALL go to FIX.
REQ-018 The FIX edge SHALL load p with the accumulator (two's-complement negated if the sign is 1), assert done for exactly that following cycle, and return to IDLE.
REQ-019 Latency: done=1 in the cycle after the (WIDTH+1)-th rising edge following the accepting edge, i.e. total WIDTH+2 edges from accept to the done cycle inclusive.
REQ-020 busy SHALL be 1 in RUN and FIX, and 0 in IDLE, including the done cycle.
REQ-021 Back-to-back: start=1 in the done cycle SHALL be accepted.
REQ-022 p SHALL change only at the FIX edge and hold its value otherwise, including across ignored starts.
REQ-023 Width rule: no overflow SHALL occur; the signed corner case (-2^(WIDTH-1))^2 = 2^(2*WIDTH-2) SHALL be represented exactly, which requires a WIDTH-bit magnitude and a 2*WIDTH-bit accumulator.
REQ-024 Zero operands SHALL still take full latency, with no early termination.

Reset
REQ-025 rst=1 at a rising edge SHALL force IDLE, busy=0, done=0, p=0, counter=0, and accumulator=0, with priority over start.
REQ-026 Reset mid-RUN or mid-FIX SHALL abort the operation: no done pulse, and p reads 0.
REQ-027 The first start SHALL be accepted on the first edge with rst=0.

Structure
REQ-028 A shared package mult_pkg SHALL hold the FSM state encoding (IDLE=0, RUN=1, FIX=2, 2-bit) and the counter-width function clog2(WIDTH+1).
REQ-029 The datapath (magnitude conversion, adder, shift register, final negation) SHALL be one sub-module seq_mult_datapath, controlled by an FSM in seq_multiplier.

Verification
REQ-030 The bench SHALL cover the following directed scenarios, each checked against a reference product computed in the bench:
- WIDTH=3, unsigned, a=7, b=7 -> p=49 (6'b110001), done in the cycle after the 4th edge post-accept.
- WIDTH=8, signed, a=-128, b=-128 -> p=16384; a=-128, b=127 -> p=-16256 (16'hC080).
- WIDTH=8, unsigned, a=0, b=255 -> p=0 after full latency; a=255, b=255 -> p=65025.
- start pulsed during RUN with different operands -> ignored; the first result is unchanged and there is exactly one done pulse.
- rst asserted on the 3rd RUN edge -> no done, p=0, busy=0 next cycle; a new start then gives the correct product.
- Back-to-back starts in the done cycle for 100 random signed and unsigned pairs -> every result correct and exactly one done pulse per accept.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM encoding and
// the counter-width helper.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Smallest r with 2**r >= n; clog2(WIDTH+1) bits hold the value WIDTH.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_mult_datapath.sv
// Datapath of the radix-2 shift-add multiplier: magnitude capture, add/shift
// accumulator and final sign fix-up into the product register.
module seq_mult_datapath
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic                 fix,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   p
);

  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic               neg_q;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_step;

  // -2^(WIDTH-1) becomes 2^(WIDTH-1), which still fits as an unsigned magnitude.
  always_comb begin
    a_mag = (signed_mode && a[WIDTH-1]) ? (~a + 1'b1) : a;
    b_mag = (signed_mode && b[WIDTH-1]) ? (~b + 1'b1) : b;
  end

  // Multiplier lives in the low half and is consumed LSB-first as the sum shifts in.
  always_comb begin
    sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
    acc_step = acc_q[0] ? {sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      p       <= '0;
    end else begin
      if (load) begin
        mcand_q <= a_mag;
        acc_q   <= {{WIDTH{1'b0}}, b_mag};
        neg_q   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
      end else if (step) begin
        acc_q <= acc_step;
      end
      if (fix) begin
        p <= neg_q ? (~acc_q + 1'b1) : acc_q;
      end
    end
  end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential radix-2 multiplier: control FSM (IDLE -> RUN x WIDTH -> FIX) driving
// the shift-add datapath; done pulses for one cycle when p updates.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  localparam int unsigned CW = clog2(WIDTH + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q;
  logic          load, step, fix;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    step    = 1'b0;
    fix     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          cnt_d   = CW'(WIDTH);
          state_d = RUN;
        end
      end
      RUN: begin
        step  = 1'b1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        fix     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= fix;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;

  seq_mult_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .step       (step),
    .fix        (fix),
    .signed_mode(signed_mode),
    .a          (a),
    .b          (b),
    .p          (p)
  );

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: stimulus pushes expected products and done
// cycles; negedge monitors pop and compare whenever done is seen.
module tb_seq_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst, start, sm, busy, done;
  logic [7:0]  a, b;
  logic [15:0] p;

  logic        rst3, start3, sm3, busy3, done3;
  logic [2:0]  a3, b3;
  logic [5:0]  p3;

  seq_multiplier #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_mode(sm), .a(a), .b(b),
    .busy(busy), .done(done), .p(p)
  );

  seq_multiplier #(.WIDTH(3)) dut3 (
    .clk(clk), .rst(rst3), .start(start3), .signed_mode(sm3), .a(a3), .b(b3),
    .busy(busy3), .done(done3), .p(p3)
  );

  typedef struct {
    logic [15:0] p;
    int unsigned cyc;
    string       name;
  } exp_t;

  exp_t q[$];
  exp_t q3[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_done: got done=1 at cycle %0d, expected none", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check({e.name, "/p"}, 32'(p), 32'(e.p));
        check({e.name, "/lat"}, cyc, e.cyc);
        check({e.name, "/busy"}, 32'(busy), 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (done3 === 1'b1) begin
      if (q3.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_done3: got done=1 at cycle %0d, expected none", cyc);
      end else begin
        exp_t e;
        e = q3.pop_front();
        check({e.name, "/p"}, 32'(p3), 32'(e.p));
        check({e.name, "/lat"}, cyc, e.cyc);
      end
    end
  end

  function automatic logic [15:0] ref_mul(input logic s, input logic [7:0] x, input logic [7:0] y);
    logic signed [15:0] xs, ys;
    if (s) begin
      xs = $signed(x);
      ys = $signed(y);
      return xs * ys;
    end
    return {8'd0, x} * {8'd0, y};
  endfunction

  // Call just after a negedge; returns #1 after the accepting edge.
  task automatic issue(input logic s, input logic [7:0] av, input logic [7:0] bv,
                       input logic [15:0] ep, input string name, input bit expect_done);
    exp_t e;
    start = 1'b1;
    sm    = s;
    a     = av;
    b     = bv;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (expect_done) begin
      e.p    = ep;
      e.cyc  = cyc + 9;
      e.name = name;
      q.push_back(e);
    end
  endtask

  // Leaves the caller at the negedge of the done cycle.
  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s/timeout: got no done in 40 cycles, expected done", name);
    end
  endtask

  initial begin
    exp_t        e3;
    logic        rs;
    logic [7:0]  ra, rb;
    bit          seen3;

    rst = 1'b1; start = 1'b0; sm = 1'b0; a = '0; b = '0;
    rst3 = 1'b1; start3 = 1'b0; sm3 = 1'b0; a3 = '0; b3 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst/busy", 32'(busy), 32'd0);
    check("rst/done", 32'(done), 32'd0);
    check("rst/p", 32'(p), 32'd0);
    check("rst/p3", 32'(p3), 32'd0);

    // WIDTH=3: 7*7 = 49, done four edges after the accepting edge.
    rst3 = 1'b0; start3 = 1'b1; sm3 = 1'b0; a3 = 3'd7; b3 = 3'd7;
    @(posedge clk);
    #1;
    start3 = 1'b0;
    e3.p = 16'd49; e3.cyc = cyc + 4; e3.name = "w3_7x7";
    q3.push_back(e3);
    seen3 = 1'b0;
    for (int i = 0; i < 20 && !seen3; i++) begin
      @(negedge clk);
      if (done3 === 1'b1) seen3 = 1'b1;
    end
    if (!seen3) begin
      n_cmp++;
      n_bad++;
      $display("FAIL w3/timeout: got no done, expected done");
    end

    // First edge with rst=0 must accept.
    @(negedge clk);
    rst = 1'b0;
    issue(1'b0, 8'd0, 8'd255, 16'd0, "u_0x255", 1'b1);
    wait_done("u_0x255");
    @(negedge clk);
    issue(1'b0, 8'd255, 8'd255, 16'd65025, "u_255x255", 1'b1);
    wait_done("u_255x255");
    @(negedge clk);
    issue(1'b1, 8'h80, 8'h80, 16'd16384, "s_m128xm128", 1'b1);
    wait_done("s_m128xm128");
    @(negedge clk);
    issue(1'b1, 8'h80, 8'h7f, 16'hC080, "s_m128x127", 1'b1);
    wait_done("s_m128x127");

    // Start during RUN is ignored; p holds until the FIX edge.
    @(negedge clk);
    issue(1'b0, 8'd12, 8'd10, 16'd120, "ign_12x10", 1'b1);
    repeat (3) @(negedge clk);
    check("ign/p_hold", 32'(p), 32'hC080);
    start = 1'b1; sm = 1'b1; a = 8'd99; b = 8'd77;
    @(negedge clk);
    start = 1'b0;
    check("ign/busy", 32'(busy), 32'd1);
    wait_done("ign_12x10");
    repeat (12) @(negedge clk);

    // Reset on the 3rd RUN edge aborts with no done.
    issue(1'b0, 8'd200, 8'd3, 16'd600, "abort", 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort/busy", 32'(busy), 32'd0);
    check("abort/done", 32'(done), 32'd0);
    check("abort/p", 32'(p), 32'd0);
    rst = 1'b0;
    issue(1'b1, 8'hFB, 8'd7, 16'hFFDD, "after_abort", 1'b1);
    wait_done("after_abort");

    // Back-to-back: next start is held high in each done cycle.
    @(negedge clk);
    rs = 1'($urandom_range(0, 1));
    ra = 8'($urandom);
    rb = 8'($urandom);
    issue(rs, ra, rb, ref_mul(rs, ra, rb), "b2b", 1'b1);
    for (int k = 1; k < 100; k++) begin
      wait_done("b2b");
      rs = 1'($urandom_range(0, 1));
      ra = 8'($urandom);
      rb = 8'($urandom);
      issue(rs, ra, rb, ref_mul(rs, ra, rb), "b2b", 1'b1);
    end
    wait_done("b2b");

    repeat (15) @(negedge clk);
    check("q_empty", 32'(q.size()), 32'd0);
    check("q3_empty", 32'(q3.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
